vc_shiftregisters_2d_win: RTL and testbench
===========================================

Name: vc_shiftregisters_2d_win

Overview:
2D sliding-window shift register array with ready/valid handshakes on both the column input and the window output.
- Accepts one HEIGHT-element column per transfer and shifts it into HEIGHT parallel WIDTH-deep row shift registers.
- Presents the full HEIGHT x WIDTH window once WIDTH columns have been accumulated, then again every STRIDE accepted columns.
- Adds fill tracking, stride decimation, backpressure and a synchronous clear.
- Sits between a column/pixel streamer and a windowed compute array (convolution/stencil PEs).

Parameters:
DATA_WIDTH, 8, bits per element
HEIGHT, 4, rows (elements per input column)
WIDTH, 8, columns held in the window (shift depth); must be >= 2
STRIDE, 1, accepted columns between successive windows after the first; legal range 1..WIDTH

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
clear  input  1  synchronous flush of fill/stride/window state
col_in  input  DATA_WIDTH*HEIGHT  input column; row r at bits [(r+1)*DATA_WIDTH-1 : r*DATA_WIDTH]
col_val  input  1  column valid
col_rdy  output  1  column ready
win_out  output  DATA_WIDTH*HEIGHT*WIDTH  window; row r occupies slice r*DATA_WIDTH*WIDTH; within a row, element j at slice j*DATA_WIDTH; j=0 newest column, j=WIDTH-1 oldest
win_val  output  1  window valid
win_rdy  input  1  window ready (consumer accepts when win_val && win_rdy)
fill_out  output  WIDTH  bit j = 1 iff element column j holds accepted data (thermometer, bit 0 fills first)

Behaviour:
- Reset (reset=1 at clk edge):
  - all data registers = 0, fill count = 0, stride count = 0, win_val = 0.
  - fill_out = 0, win_out = 0.
  - col_rdy = 1 in the first cycle after reset.
- Counters: fill_cnt in 0..WIDTH, saturating at WIDTH; stride_cnt in 0..STRIDE-1. fill_out is the thermometer encoding of fill_cnt.
- col_rdy is combinational: col_rdy = !clear && (!win_val || win_rdy).
- Accept = col_val && col_rdy. On accept, all rows shift by one:
  - element j receives element j-1; element 0 receives col_in.
  - element WIDTH-1 is discarded.
  - With no accept, all data registers hold.
- Window state machine (FILL / STEADY / PEND), evaluated on accept:
  - FILL (fill_cnt < WIDTH): fill_cnt++. If fill_cnt was WIDTH-1, set win_val=1, stride_cnt=0, go to PEND.
  - STEADY (fill_cnt == WIDTH, win_val=0): if stride_cnt == STRIDE-1, set win_val=1, stride_cnt=0, go to PEND; otherwise stride_cnt++.
  - PEND (win_val=1): an accept occurs only together with win_rdy=1 (consume). The accept is then processed as in STEADY in the same cycle: win_val stays 1 if a new window completes, else win_val clears.
  - win_val && win_rdy with no accept: win_val clears next cycle → STEADY.
- Latency: win_val rises one cycle after the accept that completes a window. win_out is stable for as long as win_val=1 and win_rdy=0.
- STRIDE=1 with continuous col_val and win_rdy: one window per cycle, win_val held high.
- clear=1:
  - next cycle: fill_cnt=0, stride_cnt=0, win_val=0.
  - data registers are not zeroed.
  - any column presented in the clear cycle is not accepted (col_rdy=0).
  - clear takes priority over a simultaneous win_rdy consume; the pending window is dropped.
- reset takes priority over clear and over all handshakes. Reset mid-window discards the pending window and all fill state.
- Windows are never dropped or duplicated, except via clear/reset.
- The input never overwrites a pending, unconsumed window.

Test Plan:
1. Reset: assert reset 2 cycles with col_val=1 → win_val=0, fill_out=0, win_out=0 throughout; col_rdy=1 the cycle after reset deasserts.
2. Fill (HEIGHT=2, WIDTH=4, STRIDE=1, win_rdy=1): push columns {row1,row0} = {0x11,0x01}..{0x14,0x04} back-to-back.
   - fill_out steps 0001, 0011, 0111, 1111.
   - win_val=1 the cycle after the 4th accept.
   - row0 = [0]0x04 [1]0x03 [2]0x02 [3]0x01; row1 = 0x14..0x11.
3. Stride (STRIDE=2): after the first window, push 0x05..0x08 (row0).
   - windows appear only after 0x06 (row0 = 06,05,04,03) and after 0x08 (row0 = 08,07,06,05).
   - no window after 0x05 or 0x07.
4. Backpressure: window pending with win_rdy=0 for 3 cycles while col_val=1.
   - col_rdy=0 and win_out unchanged for all 3 cycles.
   - raise win_rdy → the column is accepted in that cycle and the window is consumed exactly once.
5. Clear mid-fill: accept 2 columns, pulse clear with col_val=1.
   - that column is not accepted; fill_out=0 next cycle.
   - the next window appears only after 4 further accepts.
6. Streaming (STRIDE=1): col_val=win_rdy=1 for 10 cycles after fill.
   - win_val stays 1 and win_out advances by one column every cycle.
   - drop win_rdy for 1 cycle → exactly one column stalls, no window lost.

Source files
------------

// File: rtl/vc_shiftregisters_2d_win_if.sv
// ============================================================================
// Module  : vc_shiftregisters_2d_win_if
// Brief   : Column-in / window-out handshake bundle for the 2D window shifter.
//           master = producer/consumer side, slave = window shifter side.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface vc_shiftregisters_2d_win_if #(
  parameter int DATA_WIDTH = 8,
  parameter int HEIGHT     = 4,
  parameter int WIDTH      = 8
);
  logic                               clear;
  logic [DATA_WIDTH*HEIGHT-1:0]       col_in;
  logic                               col_val;
  logic                               col_rdy;
  logic [DATA_WIDTH*HEIGHT*WIDTH-1:0] win_out;
  logic                               win_val;
  logic                               win_rdy;
  logic [WIDTH-1:0]                   fill_out;

  modport master (
    output clear, col_in, col_val, win_rdy,
    input  col_rdy, win_out, win_val, fill_out
  );

  modport slave (
    input  clear, col_in, col_val, win_rdy,
    output col_rdy, win_out, win_val, fill_out
  );
endinterface

`default_nettype wire

// File: rtl/vc_shiftregisters_2d_win.sv
// ============================================================================
// Module  : vc_shiftregisters_2d_win
// Brief   : HEIGHT parallel WIDTH-deep row shift registers forming a sliding
//           HEIGHT x WIDTH window, with fill tracking, stride decimation,
//           ready/valid backpressure and a synchronous clear.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module vc_shiftregisters_2d_win #(
  parameter int DATA_WIDTH = 8,
  parameter int HEIGHT     = 4,
  parameter int WIDTH      = 8,   // >= 2
  parameter int STRIDE     = 1    // 1..WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  vc_shiftregisters_2d_win_if.slave bus
);

  localparam int c_FCW = $clog2(WIDTH + 1);
  localparam int c_SCW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [c_FCW-1:0] c_FILL_LAST   = c_FCW'(WIDTH - 1);
  localparam logic [c_SCW-1:0] c_STRIDE_LAST = c_SCW'(STRIDE - 1);

  // FILL: window not yet full; STEADY: full, counting stride; PEND: window held
  localparam logic [1:0] c_ST_FILL   = 2'd0;
  localparam logic [1:0] c_ST_STEADY = 2'd1;
  localparam logic [1:0] c_ST_PEND   = 2'd2;

  logic [1:0]            r_state;
  logic [c_FCW-1:0]      r_fill_cnt;
  logic [c_SCW-1:0]      r_stride_cnt;
  logic [DATA_WIDTH-1:0] r_data [HEIGHT][WIDTH];

  logic w_win_val;
  logic w_col_rdy;
  logic w_accept;
  logic w_stride_hit;

  // A pending window may only be overwritten in the cycle it is consumed
  assign w_win_val    = (r_state == c_ST_PEND);
  assign w_col_rdy    = !bus.clear && (!w_win_val || bus.win_rdy);
  assign w_accept     = bus.col_val && w_col_rdy;
  assign w_stride_hit = (r_stride_cnt == c_STRIDE_LAST);

  // Row shift registers: element 0 takes the new column, oldest drops off
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < HEIGHT; r++) begin
        for (int j = 0; j < WIDTH; j++) begin
          r_data[r][j] <= '0;
        end
      end
    end else if (w_accept) begin
      for (int r = 0; r < HEIGHT; r++) begin
        r_data[r][0] <= bus.col_in[r*DATA_WIDTH +: DATA_WIDTH];
        for (int j = 1; j < WIDTH; j++) begin
          r_data[r][j] <= r_data[r][j-1];
        end
      end
    end
  end

  // Window control: fill count, stride count and pending-window state
  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      r_state      <= c_ST_FILL;
      r_fill_cnt   <= '0;
      r_stride_cnt <= '0;
    end else begin
      case (r_state)
        c_ST_FILL: begin
          if (w_accept) begin
            r_fill_cnt <= r_fill_cnt + c_FCW'(1);
            if (r_fill_cnt == c_FILL_LAST) begin
              r_state      <= c_ST_PEND;
              r_stride_cnt <= '0;
            end
          end
        end
        c_ST_STEADY: begin
          if (w_accept) begin
            if (w_stride_hit) begin
              r_state      <= c_ST_PEND;
              r_stride_cnt <= '0;
            end else begin
              r_stride_cnt <= r_stride_cnt + c_SCW'(1);
            end
          end
        end
        c_ST_PEND: begin
          // Consume; a same-cycle accept may immediately complete the next window
          if (bus.win_rdy) begin
            if (w_accept && w_stride_hit) begin
              r_state      <= c_ST_PEND;
              r_stride_cnt <= '0;
            end else if (w_accept) begin
              r_state      <= c_ST_STEADY;
              r_stride_cnt <= r_stride_cnt + c_SCW'(1);
            end else begin
              r_state <= c_ST_STEADY;
            end
          end
        end
        default: begin
          r_state <= c_ST_FILL;
        end
      endcase
    end
  end

  assign bus.col_rdy = w_col_rdy;
  assign bus.win_val = w_win_val;

  generate
    for (genvar g_r = 0; g_r < HEIGHT; g_r++) begin : g_row
      for (genvar g_j = 0; g_j < WIDTH; g_j++) begin : g_col
        assign bus.win_out[(g_r*WIDTH + g_j)*DATA_WIDTH +: DATA_WIDTH] = r_data[g_r][g_j];
      end
    end

    for (genvar g_t = 0; g_t < WIDTH; g_t++) begin : g_therm
      assign bus.fill_out[g_t] = (r_fill_cnt > c_FCW'(g_t));
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_vc_shiftregisters_2d_win.sv
// ============================================================================
// Module  : tb_vc_shiftregisters_2d_win
// Brief   : Self-checking bench; STRIDE=1 and STRIDE=2 instances share the
//           stimulus, a reference model predicts windows into per-instance
//           queues that are checked against the DUT output.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vc_shiftregisters_2d_win;

  localparam int DW = 8;
  localparam int H  = 2;
  localparam int W  = 4;
  localparam int WW = DW*H*W;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          col_val;
  logic          win_rdy;
  logic [DW*H-1:0] col_in;

  vc_shiftregisters_2d_win_if #(.DATA_WIDTH(DW), .HEIGHT(H), .WIDTH(W)) bus1 ();
  vc_shiftregisters_2d_win_if #(.DATA_WIDTH(DW), .HEIGHT(H), .WIDTH(W)) bus2 ();

  assign bus1.clear = clear;  assign bus2.clear = clear;
  assign bus1.col_in = col_in; assign bus2.col_in = col_in;
  assign bus1.col_val = col_val; assign bus2.col_val = col_val;
  assign bus1.win_rdy = win_rdy; assign bus2.win_rdy = win_rdy;

  vc_shiftregisters_2d_win #(.DATA_WIDTH(DW), .HEIGHT(H), .WIDTH(W), .STRIDE(1)) u_s1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );
  vc_shiftregisters_2d_win #(.DATA_WIDTH(DW), .HEIGHT(H), .WIDTH(W), .STRIDE(2)) u_s2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  always #5 clk = ~clk;

  // Index 0 = STRIDE 1 instance, index 1 = STRIDE 2 instance
  logic          d_rdy  [2];
  logic          d_val  [2];
  logic [W-1:0]  d_fill [2];
  logic [WW-1:0] d_win  [2];
  assign d_rdy[0] = bus1.col_rdy;  assign d_rdy[1] = bus2.col_rdy;
  assign d_val[0] = bus1.win_val;  assign d_val[1] = bus2.win_val;
  assign d_fill[0] = bus1.fill_out; assign d_fill[1] = bus2.fill_out;
  assign d_win[0] = bus1.win_out;  assign d_win[1] = bus2.win_out;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model state
  int            m_fill   [2];
  int            m_stride [2];
  bit            m_val    [2];
  logic [DW-1:0] m_data   [2][H][W];
  logic [WW-1:0] q0 [$];
  logic [WW-1:0] q1 [$];
  int            stride_of [2] = '{1, 2};

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_fill[k] = 0; m_stride[k] = 0; m_val[k] = 1'b0;
      for (int r = 0; r < H; r++) for (int j = 0; j < W; j++) m_data[k][r][j] = '0;
    end
  end

  function automatic logic [WW-1:0] pack_win(input int k);
    logic [WW-1:0] w;
    w = '0;
    for (int r = 0; r < H; r++)
      for (int j = 0; j < W; j++)
        w[(r*W + j)*DW +: DW] = m_data[k][r][j];
    return w;
  endfunction

  function automatic logic [W-1:0] therm(input int n);
    logic [W-1:0] t;
    for (int j = 0; j < W; j++) t[j] = (j < n);
    return t;
  endfunction

  function automatic logic [WW-1:0] q_front(input int k);
    if (k == 0) return (q0.size() > 0) ? q0[0] : 'x;
    return (q1.size() > 0) ? q1[0] : 'x;
  endfunction

  task automatic q_push(input int k, input logic [WW-1:0] v);
    if (k == 0) q0.push_back(v); else q1.push_back(v);
  endtask

  task automatic q_pop(input int k);
    if (k == 0) begin if (q0.size() > 0) void'(q0.pop_front()); end
    else begin if (q1.size() > 0) void'(q1.pop_front()); end
  endtask

  // Monitor: compare DUT against the model, then advance the model to the next edge
  always @(negedge clk) begin
    logic exp_rdy;
    logic acc;
    logic cons;
    for (int k = 0; k < 2; k++) begin
      exp_rdy = !clear && (!m_val[k] || win_rdy);
      if (mon_en) begin
        chk($sformatf("s%0d col_rdy", k), WW'(d_rdy[k]), WW'(exp_rdy));
        chk($sformatf("s%0d win_val", k), WW'(d_val[k]), WW'(m_val[k]));
        chk($sformatf("s%0d fill_out", k), WW'(d_fill[k]), WW'(therm(m_fill[k])));
        if (m_val[k]) chk($sformatf("s%0d win_out", k), d_win[k], q_front(k));
      end
      if (reset) begin
        m_fill[k] = 0; m_stride[k] = 0; m_val[k] = 1'b0;
        for (int r = 0; r < H; r++) for (int j = 0; j < W; j++) m_data[k][r][j] = '0;
        if (k == 0) q0.delete(); else q1.delete();
      end else if (clear) begin
        if (m_val[k]) q_pop(k);
        m_val[k] = 1'b0; m_fill[k] = 0; m_stride[k] = 0;
      end else begin
        acc  = col_val && exp_rdy;
        cons = m_val[k] && win_rdy;
        if (cons) begin
          q_pop(k);
          m_val[k] = 1'b0;
        end
        if (acc) begin
          for (int r = 0; r < H; r++) begin
            for (int j = W-1; j > 0; j--) m_data[k][r][j] = m_data[k][r][j-1];
            m_data[k][r][0] = col_in[r*DW +: DW];
          end
          if (m_fill[k] < W) begin
            m_fill[k]++;
            if (m_fill[k] == W) begin
              m_stride[k] = 0; q_push(k, pack_win(k)); m_val[k] = 1'b1;
            end
          end else if (m_stride[k] == stride_of[k] - 1) begin
            m_stride[k] = 0; q_push(k, pack_win(k)); m_val[k] = 1'b1;
          end else begin
            m_stride[k]++;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] r1, input logic [7:0] r0);
    col_val = v;
    col_in  = {r1, r0};
  endtask

  // Stimulus and directed boundary checks
  initial begin
    reset = 1'b1; clear = 1'b0; win_rdy = 1'b1;
    drive(1'b1, 8'hEE, 8'hEE);

    // Reset held two cycles with col_val high
    cyc(); mon_en = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #2;
      for (int k = 0; k < 2; k++) begin
        chk("rst win_val", WW'(d_val[k]), '0);
        chk("rst fill_out", WW'(d_fill[k]), '0);
        chk("rst win_out", d_win[k], '0);
      end
      if (c == 0) cyc();
    end
    reset = 1'b0; drive(1'b0, 8'h00, 8'h00);
    cyc(); #2;
    for (int k = 0; k < 2; k++) chk("post-rst col_rdy", WW'(d_rdy[k]), WW'(1));

    // Fill four columns back to back
    for (int n = 1; n <= 4; n++) begin
      drive(1'b1, 8'(8'h10 + n), 8'(n));
      cyc(); #2;
      for (int k = 0; k < 2; k++) begin
        chk("fill step", WW'(d_fill[k]), WW'((1 << n) - 1));
        chk("fill win_val", WW'(d_val[k]), WW'(n == 4));
      end
    end
    for (int k = 0; k < 2; k++) begin
      chk("fill row0", WW'(d_win[k][31:0]), WW'(32'h01020304));
      chk("fill row1", WW'(d_win[k][63:32]), WW'(32'h11121314));
    end

    // Stride: the STRIDE=2 instance emits only every second column
    for (int n = 5; n <= 8; n++) begin
      drive(1'b1, 8'(8'h10 + n), 8'(n));
      cyc(); #2;
      chk("s1 stream val", WW'(d_val[0]), WW'(1));
      chk("s2 stride val", WW'(d_val[1]), WW'(n % 2 == 0));
      if (n == 6) chk("s2 stride win6", WW'(d_win[1][31:0]), WW'(32'h03040506));
      if (n == 8) chk("s2 stride win8", WW'(d_win[1][31:0]), WW'(32'h05060708));
    end

    // Backpressure: both windows pending, consumer stalls three cycles
    drive(1'b1, 8'h19, 8'h09);
    win_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        chk("bp col_rdy", WW'(d_rdy[k]), '0);
        chk("bp win_out", WW'(d_win[k][31:0]), WW'(32'h05060708));
      end
      cyc(); #2;
    end
    win_rdy = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) chk("bp release rdy", WW'(d_rdy[k]), WW'(1));
    cyc(); #2;
    chk("bp s2 consumed", WW'(d_val[1]), '0);
    chk("bp s1 next win", WW'(d_win[0][31:0]), WW'(32'h06070809));

    // Clear mid-fill: the column presented with clear is dropped
    drive(1'b0, 8'h00, 8'h00);
    clear = 1'b1;
    cyc(); clear = 1'b0; #2;
    for (int k = 0; k < 2; k++) chk("clr fill", WW'(d_fill[k]), '0);
    drive(1'b1, 8'h31, 8'h21); cyc();
    drive(1'b1, 8'h32, 8'h22); cyc();
    drive(1'b1, 8'h33, 8'h23); clear = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) chk("clr col_rdy", WW'(d_rdy[k]), '0);
    cyc(); clear = 1'b0; #2;
    for (int k = 0; k < 2; k++) begin
      chk("clr fill0", WW'(d_fill[k]), '0);
      chk("clr win_val", WW'(d_val[k]), '0);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'h34 + i), 8'(8'h24 + i));
      cyc(); #2;
      for (int k = 0; k < 2; k++) chk("refill val", WW'(d_val[k]), WW'(i == 3));
    end
    for (int k = 0; k < 2; k++) chk("refill row0", WW'(d_win[k][31:0]), WW'(32'h24252627));

    // Streaming at STRIDE=1: one window per cycle
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'(8'h40 + i), 8'(8'h30 + i));
      cyc(); #2;
      chk("stream val", WW'(d_val[0]), WW'(1));
      chk("stream newest", WW'(d_win[0][7:0]), WW'(8'(8'h30 + i)));
    end
    drive(1'b1, 8'h4A, 8'h3A);
    win_rdy = 1'b0;
    #1; chk("stall col_rdy", WW'(d_rdy[0]), '0);
    cyc(); #2;
    chk("stall held", WW'(d_win[0][7:0]), WW'(8'h39));
    win_rdy = 1'b1;
    #1; chk("resume col_rdy", WW'(d_rdy[0]), WW'(1));
    cyc(); #2;
    chk("resume newest", WW'(d_win[0][7:0]), WW'(8'h3A));

    // Drain remaining windows through the scoreboard
    drive(1'b0, 8'h00, 8'h00);
    repeat (4) cyc();
    #2;
    for (int k = 0; k < 2; k++) chk("drain val", WW'(d_val[k]), '0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
